motion_update_broadcaster: RTL and testbench

MOTION_UPDATE_BROADCASTER -- requirements
Module: motion_update_broadcaster

---
 rtl/md_motion_update_pkg.sv | 17 +
 rtl/motion_update_broadcaster_if.sv | 32 +++
 rtl/motion_update_broadcaster_dst_cell.sv | 22 ++
 rtl/motion_update_broadcaster.sv | 160 ++++++++++++++++
 tb/tb_motion_update_broadcaster.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/md_motion_update_pkg.sv
// rtl/md_motion_update_pkg.sv - shared state encoding and default widths for the motion update broadcaster
package md_motion_update_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_PARTICLE_NUM  = 220;
  localparam int DEF_ADDR_WIDTH    = 8;
  localparam int DEF_CELL_ID_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ_NUM = 3'd1,
    LOAD_NUM = 3'd2,
    STREAM   = 3'd3,
    FINISH   = 3'd4
  } state_e;

endpackage

// File: rtl/motion_update_broadcaster_if.sv
// rtl/motion_update_broadcaster_if.sv - cell read and broadcast bus of the motion update broadcaster
// master: broadcaster side (drives read address/enable and broadcast outputs)
// slave : environment side (drives start and the cell readout)
interface motion_update_broadcaster_if #(
  parameter int DATA_WIDTH    = md_motion_update_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = md_motion_update_pkg::DEF_ADDR_WIDTH,
  parameter int CELL_ID_WIDTH = md_motion_update_pkg::DEF_CELL_ID_WIDTH
);

  logic                       start;
  logic [ADDR_WIDTH-1:0]      out_read_address;
  logic                       out_rden;
  logic [3*DATA_WIDTH-1:0]    in_particle_info;
  logic                       out_motion_update_enable;
  logic [3*DATA_WIDTH-1:0]    out_data;
  logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell;
  logic                       out_data_valid;
  logic                       out_done;

  modport master (
    input  start, in_particle_info,
    output out_read_address, out_rden, out_motion_update_enable,
           out_data, out_data_dst_cell, out_data_valid, out_done
  );

  modport slave (
    output start, in_particle_info,
    input  out_read_address, out_rden, out_motion_update_enable,
           out_data, out_data_dst_cell, out_data_valid, out_done
  );

endinterface

// File: rtl/motion_update_broadcaster_dst_cell.sv
// rtl/motion_update_broadcaster_dst_cell.sv - maps a fixed-point position to its destination cell ID
// pos_i  : {posz, posy, posx}, DATA_WIDTH bits each
// cell_o : {cell_x, cell_y, cell_z}, the CELL_ID_WIDTH MSBs of each component
module motion_update_dst_cell
  import md_motion_update_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int CELL_ID_WIDTH = DEF_CELL_ID_WIDTH
) (
  input  logic [3*DATA_WIDTH-1:0]    pos_i,
  output logic [3*CELL_ID_WIDTH-1:0] cell_o
);

  assign cell_o = {pos_i[DATA_WIDTH-1   -: CELL_ID_WIDTH],
                   pos_i[2*DATA_WIDTH-1 -: CELL_ID_WIDTH],
                   pos_i[3*DATA_WIDTH-1 -: CELL_ID_WIDTH]};

  // Fractional bits below the cell index never select a cell.
  logic unused_fraction;
  assign unused_fraction = ^pos_i;

endmodule

// File: rtl/motion_update_broadcaster.sv
// rtl/motion_update_broadcaster.sv - reads one cell (count at address 0, particles at 1..N) and broadcasts every position
// clk : rising-edge clock
// rst : asynchronous active-high reset
// bus : motion_update_broadcaster_if.master (start, cell read port, broadcast outputs, done pulse)
// Optional macro MOTION_UPDATE_OUT_REG_EN adds one register stage on the broadcast outputs and out_done.
module motion_update_broadcaster
  import md_motion_update_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PARTICLE_NUM  = DEF_PARTICLE_NUM,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int CELL_ID_WIDTH = DEF_CELL_ID_WIDTH
) (
  input logic                       clk,
  input logic                       rst,
  motion_update_broadcaster_if.master bus
);

  // One extra bit so a count of 2^ADDR_WIDTH-1 can step past the last address.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] PNUM = CNT_W'(PARTICLE_NUM);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         num_q, num_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     en_q, en_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic [3*DATA_WIDTH-1:0]  data_q, data_d;

  logic [CNT_W-1:0]         n_raw, n_clamped;
  logic                     rden;
  logic [ADDR_WIDTH-1:0]    raddr;
  logic                     stream_done;
  logic [3*CELL_ID_WIDTH-1:0] dst_cell;

  always_comb begin
    n_raw      = {1'b0, bus.in_particle_info[ADDR_WIDTH-1:0]};
    n_clamped  = (n_raw > PNUM) ? PNUM : n_raw;
    // en_q gates the exit so an empty cell still gets a one-cycle enable window.
    stream_done = (cnt_q > num_q) && !rd_valid_q && en_q;

    state_d    = state_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    rden       = 1'b0;
    raddr      = '0;
    rd_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = READ_NUM;
      end
      READ_NUM: begin
        rden    = 1'b1;
        state_d = LOAD_NUM;
      end
      LOAD_NUM: begin
        // The count arrives this cycle; address 1 is issued right away so there is no gap.
        num_d = n_clamped;
        cnt_d = CNT_W'(1);
        if (n_clamped != '0) begin
          rden       = 1'b1;
          raddr      = ADDR_WIDTH'(1);
          rd_valid_d = 1'b1;
          cnt_d      = CNT_W'(2);
        end
        state_d = STREAM;
      end
      STREAM: begin
        if (cnt_q <= num_q) begin
          rden       = 1'b1;
          raddr      = cnt_q[ADDR_WIDTH-1:0];
          rd_valid_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
        if (stream_done) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    en_d    = (state_q == STREAM) && !stream_done;
    valid_d = rd_valid_q;
    data_d  = rd_valid_q ? bus.in_particle_info : '0;
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      en_q       <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  // data_q is zero whenever invalid, so the derived cell ID is zero too.
  motion_update_dst_cell #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CELL_ID_WIDTH (CELL_ID_WIDTH)
  ) u_dst_cell (
    .pos_i  (data_q),
    .cell_o (dst_cell)
  );

  assign bus.out_rden         = rden;
  assign bus.out_read_address = raddr;

`ifdef MOTION_UPDATE_OUT_REG_EN
  logic                       en_r_q, valid_r_q, done_r_q;
  logic [3*DATA_WIDTH-1:0]    data_r_q;
  logic [3*CELL_ID_WIDTH-1:0] dst_r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r_q    <= 1'b0;
      valid_r_q <= 1'b0;
      done_r_q  <= 1'b0;
      data_r_q  <= '0;
      dst_r_q   <= '0;
    end else begin
      en_r_q    <= en_q;
      valid_r_q <= valid_q;
      done_r_q  <= done_q;
      data_r_q  <= data_q;
      dst_r_q   <= dst_cell;
    end
  end

  assign bus.out_motion_update_enable = en_r_q;
  assign bus.out_data_valid           = valid_r_q;
  assign bus.out_done                 = done_r_q;
  assign bus.out_data                 = data_r_q;
  assign bus.out_data_dst_cell        = dst_r_q;
`else
  assign bus.out_motion_update_enable = en_q;
  assign bus.out_data_valid           = valid_q;
  assign bus.out_done                 = done_q;
  assign bus.out_data                 = data_q;
  assign bus.out_data_dst_cell        = dst_cell;
`endif

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// tb/tb_motion_update_broadcaster.sv - directed self-checking bench for motion_update_broadcaster
module tb_motion_update_broadcaster;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  motion_update_broadcaster_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .CELL_ID_WIDTH(4)
  ) bus ();

  motion_update_broadcaster #(
    .DATA_WIDTH(32), .PARTICLE_NUM(220), .ADDR_WIDTH(8), .CELL_ID_WIDTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [95:0] mem [0:255];

  // Synchronous cell memory: readout valid the cycle after out_rden.
  always @(posedge clk) begin
    if (bus.out_rden) bus.in_particle_info <= mem[bus.out_read_address];
  end

  int tests_run = 0;
  int failures  = 0;

  int first_valid, last_valid, n_valid, n_en, n_done;
  int bad_data, bad_dst, valid_wo_en, nz_idle, done_with_en, last_addr;
  int en_cycles[$];
  int done_cycles[$];

  // Pulses start in cycle 0 (held through cycle hold) and records cycles 1..cycles.
  task automatic observe(input int cycles, input int hold);
    int k;
    logic [95:0] m;
    logic [11:0] exp_dst;
    first_valid = -1; last_valid = -1; n_valid = 0; n_en = 0; n_done = 0;
    bad_data = 0; bad_dst = 0; valid_wo_en = 0; nz_idle = 0; done_with_en = 0;
    last_addr = -1; k = 0;
    en_cycles.delete(); done_cycles.delete();
    @(negedge clk); bus.start = 1'b1;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (c > hold) bus.start = 1'b0;
      if (bus.out_data_valid) begin
        k++;
        n_valid++;
        if (first_valid < 0) first_valid = c;
        last_valid = c;
        m = mem[k];
        exp_dst = {m[31:28], m[63:60], m[95:92]};
        if (bus.out_data !== m) bad_data++;
        if (bus.out_data_dst_cell !== exp_dst) bad_dst++;
        if (!bus.out_motion_update_enable) valid_wo_en++;
      end else if (bus.out_data !== '0 || bus.out_data_dst_cell !== '0) begin
        nz_idle++;
      end
      if (bus.out_motion_update_enable) begin n_en++; en_cycles.push_back(c); end
      if (bus.out_done) begin
        n_done++; done_cycles.push_back(c); k = 0;
        if (bus.out_motion_update_enable) done_with_en++;
      end
      if (bus.out_rden && bus.out_read_address != 8'd0) last_addr = int'(bus.out_read_address);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.out_rden, bus.out_motion_update_enable, bus.out_data_valid, bus.out_done} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.out_rden, bus.out_motion_update_enable, bus.out_data_valid, bus.out_done});
    end
    tests_run++;
    if (bus.out_data !== '0 || bus.out_data_dst_cell !== '0) begin
      failures++; $display("FAIL reset_data: got %h/%h expected 0/0", bus.out_data, bus.out_data_dst_cell);
    end
    tests_run++;
    if (bus.out_read_address !== 8'd0) begin
      failures++; $display("FAIL reset_addr: got %0d expected 0", bus.out_read_address);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.out_rden, bus.out_motion_update_enable, bus.out_done} !== 3'b0) begin
      failures++; $display("FAIL idle_after_reset: got %b expected 000", {bus.out_rden, bus.out_motion_update_enable, bus.out_done});
    end
  endtask

  task automatic test_n3;
    mem[0] = 96'd3;
    observe(12, 0);
    tests_run++; if (first_valid !== 4) begin failures++; $display("FAIL n3_first_valid: got %0d expected 4", first_valid); end
    tests_run++; if (last_valid !== 6) begin failures++; $display("FAIL n3_last_valid: got %0d expected 6", last_valid); end
    tests_run++; if (n_valid !== 3) begin failures++; $display("FAIL n3_valid_count: got %0d expected 3", n_valid); end
    tests_run++; if (n_en !== 3 || en_cycles[0] !== 4) begin failures++; $display("FAIL n3_enable: got count %0d first %0d expected 3/4", n_en, (n_en > 0) ? en_cycles[0] : -1); end
    tests_run++; if (n_done !== 1 || done_cycles[0] !== 7) begin failures++; $display("FAIL n3_done: got count %0d cycle %0d expected 1/7", n_done, (n_done > 0) ? done_cycles[0] : -1); end
    tests_run++; if (bad_data !== 0 || bad_dst !== 0) begin failures++; $display("FAIL n3_payload: got %0d data %0d dst errors expected 0", bad_data, bad_dst); end
    tests_run++; if (valid_wo_en !== 0 || nz_idle !== 0 || done_with_en !== 0) begin failures++; $display("FAIL n3_framing: got %0d/%0d/%0d expected 0/0/0", valid_wo_en, nz_idle, done_with_en); end
    tests_run++; if (last_addr !== 3) begin failures++; $display("FAIL n3_last_addr: got %0d expected 3", last_addr); end
  endtask

  task automatic test_n0;
    mem[0] = 96'd0;
    observe(10, 0);
    tests_run++; if (n_valid !== 0) begin failures++; $display("FAIL n0_valid_count: got %0d expected 0", n_valid); end
    tests_run++; if (n_en !== 1 || en_cycles[0] !== 4) begin failures++; $display("FAIL n0_enable: got count %0d first %0d expected 1/4", n_en, (n_en > 0) ? en_cycles[0] : -1); end
    tests_run++; if (n_done !== 1 || done_cycles[0] !== 5) begin failures++; $display("FAIL n0_done: got count %0d cycle %0d expected 1/5", n_done, (n_done > 0) ? done_cycles[0] : -1); end
    tests_run++; if (last_addr !== -1) begin failures++; $display("FAIL n0_no_particle_read: got %0d expected -1", last_addr); end
  endtask

  task automatic test_dst_cell;
    mem[0] = 96'd1;
    mem[1] = {32'h1000_0000, 32'h4000_0000, 32'h3000_0000};
    observe(10, 0);
    tests_run++; if (first_valid !== 4 || n_valid !== 1) begin failures++; $display("FAIL n1_valid: got first %0d count %0d expected 4/1", first_valid, n_valid); end
    tests_run++; if (n_done !== 1 || done_cycles[0] !== 5) begin failures++; $display("FAIL n1_done: got count %0d cycle %0d expected 1/5", n_done, (n_done > 0) ? done_cycles[0] : -1); end
    tests_run++; if (bad_dst !== 0) begin failures++; $display("FAIL dst_cell_341: got %0d dst errors expected 0", bad_dst); end
    mem[0] = 96'd1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.out_data_dst_cell !== 12'h341) begin failures++; $display("FAIL dst_cell_value: got %h expected 341", bus.out_data_dst_cell); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clamp;
    mem[0] = 96'd250;
    observe(235, 0);
    tests_run++; if (n_valid !== 220) begin failures++; $display("FAIL clamp_valid_count: got %0d expected 220", n_valid); end
    tests_run++; if (last_addr !== 220) begin failures++; $display("FAIL clamp_last_addr: got %0d expected 220", last_addr); end
    tests_run++; if (n_done !== 1 || done_cycles[0] !== 224) begin failures++; $display("FAIL clamp_done: got count %0d cycle %0d expected 1/224", n_done, (n_done > 0) ? done_cycles[0] : -1); end
    tests_run++; if (bad_data !== 0 || n_en !== 220) begin failures++; $display("FAIL clamp_payload: got %0d errors enable %0d expected 0/220", bad_data, n_en); end
  endtask

  task automatic test_reset_mid;
    int seen_done, seen_en;
    mem[0] = 96'd10;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if (bus.out_data_valid !== 1'b1 || bus.out_data !== mem[2]) begin failures++; $display("FAIL mid_pre_reset: got valid %b data %h expected 1/%h", bus.out_data_valid, bus.out_data, mem[2]); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.out_rden, bus.out_motion_update_enable, bus.out_data_valid, bus.out_done} !== 4'b0 ||
        bus.out_data !== '0 || bus.out_data_dst_cell !== '0 || bus.out_read_address !== 8'd0) begin
      failures++; $display("FAIL mid_reset_outputs: got rden %b en %b valid %b addr %0d data %h expected all 0",
                           bus.out_rden, bus.out_motion_update_enable, bus.out_data_valid, bus.out_read_address, bus.out_data);
    end
    @(negedge clk); rst = 1'b0;
    seen_done = 0; seen_en = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.out_done) seen_done++;
      if (bus.out_motion_update_enable) seen_en++;
    end
    tests_run++; if (seen_done !== 0 || seen_en !== 0) begin failures++; $display("FAIL mid_reset_discard: got done %0d enable %0d expected 0/0", seen_done, seen_en); end
    mem[0] = 96'd3;
    observe(12, 0);
    tests_run++; if (n_valid !== 3 || n_done !== 1 || done_cycles[0] !== 7) begin failures++; $display("FAIL mid_reset_restart: got valid %0d done %0d expected 3 valid, done at 7", n_valid, (n_done > 0) ? done_cycles[0] : -1); end
  endtask

  task automatic test_back_to_back;
    mem[0] = 96'd2;
    observe(20, 12);
    tests_run++; if (n_done !== 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
    tests_run++; if (n_done == 2 && (done_cycles[0] !== 6 || done_cycles[1] !== 13)) begin failures++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 6,13", done_cycles[0], done_cycles[1]); end
    tests_run++;
    if (n_en !== 4 || en_cycles[0] !== 4 || en_cycles[1] !== 5 || en_cycles[2] !== 11 || en_cycles[3] !== 12) begin
      failures++; $display("FAIL b2b_enable_windows: got count %0d expected cycles 4,5,11,12", n_en);
    end
    tests_run++; if (n_valid !== 4 || bad_data !== 0 || done_with_en !== 0) begin failures++; $display("FAIL b2b_payload: got valid %0d errors %0d overlap %0d expected 4/0/0", n_valid, bad_data, done_with_en); end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k] = {32'h5000_0000 ^ 32'(k), 32'h2000_0000 + 32'(k * 7), 32'h1000_0000 + 32'(k)};
    end
    bus.start = 1'b0;
    test_reset;
    test_n3;
    test_n0;
    test_dst_cell;
    test_clamp;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
